// File: rtl/seven_seg_scan_ctrl.sv
// 3-digit multiplexed seven-segment controller: sequential double-dabble
// binary-to-BCD conversion feeding a free-running registered digit scanner.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] DataIn,
  input  logic       Load,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] DigitSel,
  output logic [7:0] SegOut
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t        state_r, stateNext_s;
  logic [19:0]   shift_r, shiftNext_s;
  logic [2:0]    iter_r, iterNext_s;
  logic          loadDisp_s;
  logic [3:0]    hund_r, tens_r, ones_r;
  logic [PW-1:0] presc_r;
  logic [1:0]    scanIdx_r, scanIdxNext_s;
  logic          scanTick_s;
  logic [3:0]    nextDigit_s;
  logic          nextBlank_s;
  logic [7:0]    nextSeg_s;
  logic [2:0]    nextSel_s;

  // Segment pattern for one BCD digit; bit7 (dp) is never lit.
  function automatic logic [7:0] segDecode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct BCD nibbles >= 5, then shift left.
  function automatic logic [19:0] dabbleStep(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  // Conversion FSM next-state and datapath decisions.
  always_comb begin
    stateNext_s = state_r;
    shiftNext_s = shift_r;
    iterNext_s  = iter_r;
    loadDisp_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Load) begin
          shiftNext_s = {12'd0, DataIn};
          iterNext_s  = 3'd0;
          stateNext_s = CONVERT;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CONVERT: begin
        shiftNext_s = dabbleStep(shift_r);
        iterNext_s  = iter_r + 3'd1;
        if (iter_r == 3'd7) begin
          stateNext_s = UPDATE;
        end else begin
          stateNext_s = CONVERT;
        end
      end
      UPDATE: begin
        loadDisp_s  = 1'b1;
        stateNext_s = IDLE;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Conversion FSM state, shift register and handshake outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
      shift_r <= 20'd0;
      iter_r  <= 3'd0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      shift_r <= shiftNext_s;
      iter_r  <= iterNext_s;
      Busy    <= (stateNext_s != IDLE);
      Done    <= loadDisp_s;
    end
  end

  // Display digit registers; written only when leaving UPDATE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hund_r <= 4'd0;
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else if (loadDisp_s) begin
      hund_r <= shift_r[19:16];
      tens_r <= shift_r[15:12];
      ones_r <= shift_r[11:8];
    end
  end

  assign scanTick_s    = (presc_r == PW'(SCAN_DIV - 1));
  assign scanIdxNext_s = (scanIdx_r == 2'd2) ? 2'd0 : (scanIdx_r + 2'd1);

  // Pattern for the slot about to be shown, including leading-zero blanking.
  always_comb begin
    nextDigit_s = ones_r;
    nextBlank_s = 1'b0;
    nextSel_s   = 3'b001;
    case (scanIdxNext_s)
      2'd0: begin
        nextDigit_s = ones_r;
        nextBlank_s = 1'b0;
        nextSel_s   = 3'b001;
      end
      2'd1: begin
        nextDigit_s = tens_r;
        nextBlank_s = BLANK_LEADING && (hund_r == 4'd0) && (tens_r == 4'd0);
        nextSel_s   = 3'b010;
      end
      2'd2: begin
        nextDigit_s = hund_r;
        nextBlank_s = BLANK_LEADING && (hund_r == 4'd0);
        nextSel_s   = 3'b100;
      end
      default: begin
        nextDigit_s = ones_r;
        nextBlank_s = 1'b0;
        nextSel_s   = 3'b001;
      end
    endcase
    nextSeg_s = nextBlank_s ? 8'h00 : segDecode(nextDigit_s);
  end

  // Prescaler and scan registers; select and segments change on the same edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      presc_r   <= '0;
      scanIdx_r <= 2'd0;
      DigitSel  <= 3'b001;
      SegOut    <= 8'h3F;
    end else if (scanTick_s) begin
      presc_r   <= '0;
      scanIdx_r <= scanIdxNext_s;
      DigitSel  <= nextSel_s;
      SegOut    <= nextSeg_s;
    end else begin
      presc_r   <= presc_r + PW'(1);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench: two controllers (blanking off/on) driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_seven_seg_scan_ctrl;

  localparam int SD = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Load = 1'b0;
  logic [7:0] DataIn = 8'd0;
  logic       busy0, done0, busy1, done1;
  logic [2:0] sel0, sel1;
  logic [7:0] seg0, seg1;

  int tests = 0;
  int fails = 0;
  int doneSeen = 0;

  // reference model state
  int n, busyUntil, latchedVal, dispVal, pendVal;
  logic [7:0] segTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always #5 Clk = ~Clk;

  seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .Load(Load),
    .Busy(busy0), .Done(done0), .DigitSel(sel0), .SegOut(seg0)
  );

  seven_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .Load(Load),
    .Busy(busy1), .Done(done1), .DigitSel(sel1), .SegOut(seg1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic modelReset();
    n = 0;
    busyUntil = -1;
    latchedVal = 0;
    dispVal = 0;
  endtask

  // One clock edge of the reference: scan latches the value shown so far,
  // a finished conversion publishes 9 edges after acceptance.
  task automatic modelEdge();
    n++;
    if (n % SD == 0) latchedVal = dispVal;
    if (n == busyUntil) dispVal = pendVal;
    if (Load && !(n - 1 < busyUntil)) begin
      pendVal = DataIn;
      busyUntil = n + 9;
    end
  endtask

  function automatic logic [7:0] expSeg(input bit blank);
    int idx, d;
    bit blk;
    idx = (n / SD) % 3;
    blk = 1'b0;
    case (idx)
      0: d = latchedVal % 10;
      1: begin d = (latchedVal / 10) % 10; blk = blank && (latchedVal < 10); end
      default: begin d = latchedVal / 100; blk = blank && (latchedVal < 100); end
    endcase
    return blk ? 8'h00 : segTab[d];
  endfunction

  task automatic checkAll();
    logic eb, ed;
    logic [2:0] es;
    eb = (n < busyUntil);
    ed = (n == busyUntil);
    es = 3'b001 << ((n / SD) % 3);
    check("busy0", {7'd0, busy0}, {7'd0, eb});
    check("busy1", {7'd0, busy1}, {7'd0, eb});
    check("done0", {7'd0, done0}, {7'd0, ed});
    check("done1", {7'd0, done1}, {7'd0, ed});
    check("sel0", {5'd0, sel0}, {5'd0, es});
    check("sel1", {5'd0, sel1}, {5'd0, es});
    check("onehot0", {7'd0, $onehot(sel0)}, 8'd1);
    check("seg0", seg0, expSeg(1'b0));
    check("seg1", seg1, expSeg(1'b1));
  endtask

  task automatic step();
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
    if (done0) doneSeen++;
    checkAll();
  endtask

  task automatic loadVal(input logic [7:0] v);
    DataIn = v;
    Load = 1'b1;
    step();
    Load = 1'b0;
    DataIn = 8'($urandom);
  endtask

  // Let the conversion finish, then record the last pattern seen in each slot.
  task automatic rotation(input string tag, input bit which,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] got [3];
    logic [2:0] s;
    logic [7:0] g;
    got[0] = 8'hxx; got[1] = 8'hxx; got[2] = 8'hxx;
    repeat (10) step();
    for (int i = 0; i < 15; i++) begin
      step();
      s = which ? sel1 : sel0;
      g = which ? seg1 : seg0;
      case (s)
        3'b001:  got[0] = g;
        3'b010:  got[1] = g;
        3'b100:  got[2] = g;
        default: got[0] = 8'hxx;
      endcase
    end
    check({tag, "_ones"}, got[0], e0);
    check({tag, "_tens"}, got[1], e1);
    check({tag, "_hund"}, got[2], e2);
  endtask

  initial begin
    modelReset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    checkAll();

    loadVal(8'd118);
    rotation("v118", 1'b0, 8'h7F, 8'h06, 8'h06);
    loadVal(8'd255);
    rotation("v255", 1'b0, 8'h6D, 8'h6D, 8'h5B);
    loadVal(8'd3);
    rotation("v3b", 1'b1, 8'h4F, 8'h00, 8'h00);
    loadVal(8'd46);
    rotation("v46b", 1'b1, 8'h7D, 8'h66, 8'h00);
    loadVal(8'd0);
    rotation("v0b", 1'b1, 8'h3F, 8'h00, 8'h00);

    // load while busy is dropped
    doneSeen = 0;
    loadVal(8'd28);
    step();
    step();
    DataIn = 8'd63;
    Load = 1'b1;
    step();
    Load = 1'b0;
    rotation("v28", 1'b0, 8'h7F, 8'h5B, 8'h3F);
    check("oneDone", 8'(doneSeen), 8'd1);

    // asynchronous reset in the 4th CONVERT cycle
    loadVal(8'd10);
    step();
    step();
    step();
    #1 Rst = 1'b1;
    #1 modelReset();
    checkAll();
    @(negedge Clk);
    Rst = 1'b0;
    checkAll();
    loadVal(8'd10);
    rotation("v10", 1'b0, 8'h3F, 8'h06, 8'h3F);

    // random loads, including requests while busy
    for (int i = 0; i < 400; i++) begin
      DataIn = 8'($urandom);
      Load = ($urandom_range(0, 3) == 0);
      step();
    end
    // Load held high: back-to-back conversions with changing data
    Load = 1'b1;
    for (int i = 0; i < 40; i++) begin
      DataIn = 8'($urandom);
      step();
    end
    Load = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
